// File: rtl/processor_pio_master.sv
// Avalon-MM PIO master: writes take 2 cycles, read response at handshake+2+READ_LATENCY, cmd_ready low while busy.
// Define PROCESSOR_PIO_MASTER_POLL_EN to add autonomous address-0 polling every POLL_PERIOD cycles.
module processor_pio_master #(
  parameter int READ_LATENCY = 1,
  parameter int POLL_PERIOD  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_address,
  input  logic [31:0] cmd_writedata,
  output logic        rsp_valid,
  output logic [31:0] rsp_readdata,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic [31:0] poll_data,
  output logic        poll_change
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
`ifdef PROCESSOR_PIO_MASTER_POLL_EN
  localparam logic [2:0] S_POLL  = 3'd4;
`endif

  // WAIT counts down from READ_LATENCY-1 to 0, so it lasts exactly READ_LATENCY cycles
  localparam logic [2:0] WAIT_RELOAD = 3'(READ_LATENCY - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [2:0]  r_wait_cnt;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_readdata;
  logic        r_avm_cs;
  logic        r_avm_wn;
  logic [1:0]  r_avm_addr;
  logic [31:0] r_avm_wdata;
  logic        w_accept;
  logic        w_read_done;
  logic        w_wait_is_poll;
`ifdef PROCESSOR_PIO_MASTER_POLL_EN
  localparam logic [15:0] POLL_LAST = 16'(POLL_PERIOD - 1);
  logic [15:0] r_poll_cnt;
  logic        r_is_poll;
  logic [31:0] r_poll_data;
  logic        r_poll_change;
  logic        w_poll_due;
  logic        w_start_poll;
`endif

  assign cmd_ready   = (r_state == S_IDLE) && !reset;
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_read_done = (r_state == S_WAIT) && (r_wait_cnt == 3'd0);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = cmd_write ? S_WRITE : S_READ;
        end
`ifdef PROCESSOR_PIO_MASTER_POLL_EN
        else if (w_start_poll) begin
          w_next_state = S_POLL;
        end
`endif
      end
      S_WRITE: w_next_state = S_IDLE;
      S_READ:  w_next_state = S_WAIT;
`ifdef PROCESSOR_PIO_MASTER_POLL_EN
      S_POLL:  w_next_state = S_WAIT;
`endif
      S_WAIT: begin
        if (r_wait_cnt == 3'd0) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Bus strobes are computed from the transition so they are registered yet aligned with WRITE/READ/POLL
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wait_cnt     <= 3'd0;
      r_rsp_valid    <= 1'b0;
      r_rsp_readdata <= 32'd0;
      r_avm_cs       <= 1'b0;
      r_avm_wn       <= 1'b1;
      r_avm_addr     <= 2'd0;
      r_avm_wdata    <= 32'd0;
    end else begin
      r_state     <= w_next_state;
      r_rsp_valid <= 1'b0;
      r_avm_cs    <= 1'b0;
      r_avm_wn    <= 1'b1;
      if (w_accept) begin
        r_avm_cs   <= 1'b1;
        r_avm_addr <= cmd_address;
        if (cmd_write) begin
          r_avm_wn    <= 1'b0;
          r_avm_wdata <= cmd_writedata;
        end else begin
          r_wait_cnt <= WAIT_RELOAD;
        end
      end
`ifdef PROCESSOR_PIO_MASTER_POLL_EN
      else if (w_start_poll) begin
        r_avm_cs   <= 1'b1;
        r_avm_addr <= 2'd0;
        r_wait_cnt <= WAIT_RELOAD;
      end
`endif
      if ((r_state == S_WAIT) && (r_wait_cnt != 3'd0)) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end
      if (w_read_done && !w_wait_is_poll) begin
        r_rsp_valid    <= 1'b1;
        r_rsp_readdata <= avm_readdata;
      end
    end
  end

`ifdef PROCESSOR_PIO_MASTER_POLL_EN
  assign w_poll_due     = (r_poll_cnt == POLL_LAST);
  // A pending command wins; the counter stays saturated so the poll is only deferred
  assign w_start_poll   = (r_state == S_IDLE) && !cmd_valid && w_poll_due;
  assign w_wait_is_poll = r_is_poll;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_poll_cnt    <= 16'd0;
      r_is_poll     <= 1'b0;
      r_poll_data   <= 32'd0;
      r_poll_change <= 1'b0;
    end else begin
      r_poll_change <= 1'b0;
      if (w_start_poll) begin
        r_poll_cnt <= 16'd0;
        r_is_poll  <= 1'b1;
      end else begin
        if (!w_poll_due) begin
          r_poll_cnt <= r_poll_cnt + 16'd1;
        end
        if (w_accept) begin
          r_is_poll <= 1'b0;
        end
      end
      if (w_read_done && r_is_poll) begin
        r_poll_data   <= avm_readdata;
        r_poll_change <= (avm_readdata != r_poll_data);
      end
    end
  end

  assign poll_data   = r_poll_data;
  assign poll_change = r_poll_change;
`else
  assign w_wait_is_poll = 1'b0;
  assign poll_data      = 32'd0;
  assign poll_change    = 1'b0;
`endif

  assign rsp_valid      = r_rsp_valid;
  assign rsp_readdata   = r_rsp_readdata;
  assign avm_address    = r_avm_addr;
  assign avm_chipselect = r_avm_cs;
  assign avm_write_n    = r_avm_wn;
  assign avm_writedata  = r_avm_wdata;

endmodule

// File: tb/tb_processor_pio_master.sv
// Directed bench: dut_a (READ_LATENCY=1), dut_b (READ_LATENCY=3), dut_c (POLL_PERIOD=8) for polling.
module tb_processor_pio_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_write;
  logic [1:0]  cmd_address;
  logic [31:0] cmd_writedata;

  logic        a_valid, a_rdy, a_rsp, a_cs, a_wn, a_pc;
  logic [31:0] a_rdata, a_wdata, a_rd, a_pd;
  logic [1:0]  a_addr;
  logic        b_valid, b_rdy, b_rsp, b_cs, b_wn, b_pc;
  logic [31:0] b_rdata, b_wdata, b_rd, b_pd;
  logic [1:0]  b_addr;
  logic        c_valid, c_rdy, c_rsp, c_cs, c_wn, c_pc;
  logic [31:0] c_rdata, c_wdata, c_rd, c_pd;
  logic [1:0]  c_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  processor_pio_master #(.READ_LATENCY(1), .POLL_PERIOD(65535)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(a_valid), .cmd_ready(a_rdy), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata), .rsp_valid(a_rsp), .rsp_readdata(a_rdata),
    .avm_address(a_addr), .avm_chipselect(a_cs), .avm_write_n(a_wn), .avm_writedata(a_wdata),
    .avm_readdata(a_rd), .poll_data(a_pd), .poll_change(a_pc));

  processor_pio_master #(.READ_LATENCY(3), .POLL_PERIOD(65535)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_rdy), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata), .rsp_valid(b_rsp), .rsp_readdata(b_rdata),
    .avm_address(b_addr), .avm_chipselect(b_cs), .avm_write_n(b_wn), .avm_writedata(b_wdata),
    .avm_readdata(b_rd), .poll_data(b_pd), .poll_change(b_pc));

  processor_pio_master #(.READ_LATENCY(1), .POLL_PERIOD(8)) dut_c (
    .clk(clk), .reset(reset), .cmd_valid(c_valid), .cmd_ready(c_rdy), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata), .rsp_valid(c_rsp), .rsp_readdata(c_rdata),
    .avm_address(c_addr), .avm_chipselect(c_cs), .avm_write_n(c_wn), .avm_writedata(c_wdata),
    .avm_readdata(c_rd), .poll_data(c_pd), .poll_change(c_pc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int found;
    int cs_hits;
    int pc_hits;
    int pd_bad;
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    cmd_write = 1'b0; cmd_address = 2'd0; cmd_writedata = 32'd0;
    a_rd = 32'd0; b_rd = 32'h0BAD0000; c_rd = 32'd0;
    repeat (3) tick();

    // reset state
    chk("rst_rdy", a_rdy, 1'b0);
    chk("rst_cs", a_cs, 1'b0);
    chk("rst_wn", a_wn, 1'b1);
    chk("rst_rsp", a_rsp, 1'b0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_addr", a_addr, 2'd0);
    chk("rst_wdata", a_wdata, 32'd0);
    chk("rst_pd", c_pd, 32'd0);
    chk("rst_pc", c_pc, 1'b0);
    reset = 1'b0;
    tick();
    chk("idle_rdy", a_rdy, 1'b1);

    // single write
    a_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd0; cmd_writedata = 32'h12345678;
    tick();
    a_valid = 1'b0;
    chk("wr_cs", a_cs, 1'b1);
    chk("wr_wn", a_wn, 1'b0);
    chk("wr_addr", a_addr, 2'd0);
    chk("wr_wdata", a_wdata, 32'h12345678);
    chk("wr_busy_rdy", a_rdy, 1'b0);
    chk("wr_rsp", a_rsp, 1'b0);
    tick();
    chk("wr_done_rdy", a_rdy, 1'b1);
    chk("wr_done_cs", a_cs, 1'b0);
    chk("wr_done_wn", a_wn, 1'b1);
    chk("wr_hold_wdata", a_wdata, 32'h12345678);
    chk("wr_done_rsp", a_rsp, 1'b0);

    // back-to-back writes: one per two cycles
    a_valid = 1'b1; cmd_address = 2'd3; cmd_writedata = 32'hDEADBEEF;
    tick();
    chk("b2b1_cs", a_cs, 1'b1);
    chk("b2b1_addr", a_addr, 2'd3);
    chk("b2b1_wdata", a_wdata, 32'hDEADBEEF);
    chk("b2b1_rdy", a_rdy, 1'b0);
    cmd_address = 2'd2; cmd_writedata = 32'h0BEEF002;
    tick();
    chk("b2b_gap_cs", a_cs, 1'b0);
    chk("b2b_gap_rdy", a_rdy, 1'b1);
    tick();
    a_valid = 1'b0;
    chk("b2b2_cs", a_cs, 1'b1);
    chk("b2b2_addr", a_addr, 2'd2);
    chk("b2b2_wdata", a_wdata, 32'h0BEEF002);
    chk("b2b2_rsp", a_rsp, 1'b0);
    tick();

    // read, READ_LATENCY=1, then a new read accepted in the rsp_valid cycle
    a_rd = 32'hCAFEF00D;
    a_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd0;
    tick();
    a_valid = 1'b0;
    chk("rd_cs", a_cs, 1'b1);
    chk("rd_wn", a_wn, 1'b1);
    chk("rd_addr", a_addr, 2'd0);
    chk("rd_rsp_early", a_rsp, 1'b0);
    tick();
    chk("rd_wait_cs", a_cs, 1'b0);
    chk("rd_wait_rsp", a_rsp, 1'b0);
    chk("rd_wait_addr", a_addr, 2'd0);
    tick();
    chk("rd_rsp", a_rsp, 1'b1);
    chk("rd_rdata", a_rdata, 32'hCAFEF00D);
    chk("rd_rsp_rdy", a_rdy, 1'b1);
    a_valid = 1'b1; cmd_address = 2'd1; a_rd = 32'h11223344;
    tick();
    a_valid = 1'b0;
    chk("rd2_rsp_off", a_rsp, 1'b0);
    chk("rd_rdata_hold", a_rdata, 32'hCAFEF00D);
    chk("rd2_cs", a_cs, 1'b1);
    chk("rd2_addr", a_addr, 2'd1);
    tick();
    chk("rd2_wait_rsp", a_rsp, 1'b0);
    tick();
    chk("rd2_rsp", a_rsp, 1'b1);
    chk("rd2_rdata", a_rdata, 32'h11223344);

    // READ_LATENCY=3: data only valid in the last WAIT cycle
    chk("lat_rdy", b_rdy, 1'b1);
    b_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd3;
    tick();
    b_valid = 1'b0;
    chk("lat_cs", b_cs, 1'b1);
    chk("lat_addr", b_addr, 2'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lat_wait%0d_cs", i), b_cs, 1'b0);
      chk($sformatf("lat_wait%0d_addr", i), b_addr, 2'd3);
      chk($sformatf("lat_wait%0d_rsp", i), b_rsp, 1'b0);
    end
    b_rd = 32'h5A5A1234;
    tick();
    b_rd = 32'h0BAD0000;
    chk("lat_rsp", b_rsp, 1'b1);
    chk("lat_rdata", b_rdata, 32'h5A5A1234);
    tick();
    chk("lat_rsp_off", b_rsp, 1'b0);
    chk("lat_rdata_hold", b_rdata, 32'h5A5A1234);

    // reset during WAIT aborts the read
    a_rd = 32'h99999999;
    a_valid = 1'b1; cmd_address = 2'd2;
    tick();
    a_valid = 1'b0;
    chk("abt_cs", a_cs, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    chk("abt_cs_off", a_cs, 1'b0);
    chk("abt_rsp", a_rsp, 1'b0);
    chk("abt_rdy", a_rdy, 1'b0);
    chk("abt_rdata", a_rdata, 32'd0);
    chk("abt_addr", a_addr, 2'd0);
    tick();
    chk("abt_rdy2", a_rdy, 1'b0);
    chk("abt_rsp2", a_rsp, 1'b0);
    reset = 1'b0;
    tick();
    chk("abt_rel_rdy", a_rdy, 1'b1);
    chk("abt_rel_rsp", a_rsp, 1'b0);
    chk("abt_rel_cs", a_cs, 1'b0);
    tick();
    chk("abt_late_rsp", a_rsp, 1'b0);

`ifdef PROCESSOR_PIO_MASTER_POLL_EN
    c_rd = 32'd0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (c_cs) found = 1;
    end
    chk("poll_seen", found, 1);
    chk("poll_addr", c_addr, 2'd0);
    chk("poll_wn", c_wn, 1'b1);
    cs_hits = 0; pc_hits = 0;
    for (int i = 1; i < 8; i++) begin
      tick();
      if (c_cs) cs_hits++;
      if (c_pc) pc_hits++;
    end
    chk("poll_gap", cs_hits, 0);
    chk("poll_zero_pc", pc_hits, 0);
    tick();
    chk("poll_period", c_cs, 1'b1);
    chk("poll_period_addr", c_addr, 2'd0);
    chk("poll_zero_pd", c_pd, 32'd0);
    c_rd = 32'h000000A5;
    pc_hits = 0;
    for (int i = 9; i < 16; i++) begin
      tick();
      if (c_pc) pc_hits++;
    end
    chk("poll_a5_pc", pc_hits, 1);
    chk("poll_a5_pd", c_pd, 32'h000000A5);
    chk("poll_no_rsp", c_rsp, 1'b0);
    chk("poll_due_rdy", c_rdy, 1'b1);
    c_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd2;
    tick();
    c_valid = 1'b0;
    chk("poll_cmd_first_cs", c_cs, 1'b1);
    chk("poll_cmd_first_addr", c_addr, 2'd2);
    c_rd = 32'h0000003C;
    tick();
    tick();
    chk("poll_cmd_rsp", c_rsp, 1'b1);
    chk("poll_cmd_rdata", c_rdata, 32'h0000003C);
    chk("poll_cmd_pd", c_pd, 32'h000000A5);
    c_rd = 32'h000000A5;
    tick();
    chk("poll_deferred_cs", c_cs, 1'b1);
    chk("poll_deferred_addr", c_addr, 2'd0);
    pc_hits = 0;
    tick();
    if (c_pc) pc_hits++;
    tick();
    if (c_pc) pc_hits++;
    chk("poll_same_pc", pc_hits, 0);
    chk("poll_same_pd", c_pd, 32'h000000A5);
`else
    cs_hits = 0; pc_hits = 0; pd_bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (c_cs) cs_hits++;
      if (c_pc) pc_hits++;
      if (c_pd != 32'd0) pd_bad++;
    end
    chk("nopoll_cs", cs_hits, 0);
    chk("nopoll_pc", pc_hits, 0);
    chk("nopoll_pd", pd_bad, 0);
    found = 0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
